// File: rtl/and_gate_behav_sync.sv
// rtl/and_gate_behav_sync.sv - bitwise AND cell with registered copy and optional activity counters.
// Counters are built only when AND_GATE_BEHAV_STATS_EN is defined; otherwise they read 0 and clr is ignored.
module and_gate_behav_sync #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_all,
  output logic             y_any,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] rise_cnt
);

  // Gate path is pure continuous logic so it works with clk/rst_n floating.
  assign y     = a & b;
  assign y_all = &y;
  assign y_any = |y;

  logic [WIDTH-1:0] y_reg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg_q <= '0;
    end else begin
      y_reg_q <= y;
    end
  end

  assign y_q = y_reg_q;

`ifdef AND_GATE_BEHAV_STATS_EN
  logic             y_any_prev_q;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;

  always_comb begin
    hi_cnt_d   = hi_cnt_q;
    rise_cnt_d = rise_cnt_q;
    if (clr) begin
      hi_cnt_d   = '0;
      rise_cnt_d = '0;
    end else begin
      if (y_any && (hi_cnt_q != '1)) begin
        hi_cnt_d = hi_cnt_q + CNT_W'(1);
      end
      if (y_any && !y_any_prev_q && (rise_cnt_q != '1)) begin
        rise_cnt_d = rise_cnt_q + CNT_W'(1);
      end
    end
  end

  // The previous-sample flop keeps tracking during clr so rise detection stays continuous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_any_prev_q <= 1'b0;
      hi_cnt_q     <= '0;
      rise_cnt_q   <= '0;
    end else begin
      y_any_prev_q <= y_any;
      hi_cnt_q     <= hi_cnt_d;
      rise_cnt_q   <= rise_cnt_d;
    end
  end

  assign hi_cnt   = hi_cnt_q;
  assign rise_cnt = rise_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign hi_cnt     = '0;
  assign rise_cnt   = '0;
`endif

endmodule

// File: tb/tb_and_gate_behav_sync.sv
// tb/tb_and_gate_behav_sync.sv - directed checks of and_gate_behav_sync in either stats build.
module tb_and_gate_behav_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       clr;
  logic [3:0] y, y_q;
  logic       y_all, y_any;
  logic [2:0] hi_cnt, rise_cnt;

  logic       ca, cb;
  logic       cy, cy_q, cy_all, cy_any;
  logic [15:0] c_hi, c_rise;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  and_gate_behav_sync #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .y(y), .y_q(y_q), .y_all(y_all), .y_any(y_any),
    .hi_cnt(hi_cnt), .rise_cnt(rise_cnt)
  );

  and_gate_behav_sync #(.WIDTH(1)) u_comb (
    .clk(1'b0), .rst_n(1'b0), .a(ca), .b(cb), .clr(1'b0),
    .y(cy), .y_q(cy_q), .y_all(cy_all), .y_any(cy_any),
    .hi_cnt(c_hi), .rise_cnt(c_rise)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ec(input int v);
`ifdef AND_GATE_BEHAV_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name, input int hi, input int rise);
    check({name, "_hi"}, {29'd0, hi_cnt}, ec(hi));
    check({name, "_rise"}, {29'd0, rise_cnt}, ec(rise));
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       all;
    logic       any;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b1};
    vecs[1] = '{4'hF,    4'hF,    4'hF,    1'b1, 1'b1};
    vecs[2] = '{4'h0,    4'hF,    4'h0,    1'b0, 1'b0};
    vecs[3] = '{4'h5,    4'hA,    4'h0,    1'b0, 1'b0};
    vecs[4] = '{4'h7,    4'hE,    4'h6,    1'b0, 1'b1};
    vecs[5] = '{4'hE,    4'hF,    4'hE,    1'b0, 1'b1};

    rst_n = 1'b0; clr = 1'b0; a = 4'h0; b = 4'h0; ca = 1'b0; cb = 1'b0;

    // Unclocked WIDTH=1 truth table
    for (int i = 0; i < 4; i++) begin
      ca = i[1]; cb = i[0];
      #1;
      check($sformatf("tt_y_%0d", i), {31'd0, cy}, (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("tt_all_%0d", i), {31'd0, cy_all}, (i == 3) ? 32'd1 : 32'd0);
      #9;
    end

    for (int i = 0; i < 6; i++) begin
      a = vecs[i].a; b = vecs[i].b;
      #1;
      check($sformatf("vec_y_%0d", i), {28'd0, y}, {28'd0, vecs[i].y});
      check($sformatf("vec_all_%0d", i), {31'd0, y_all}, {31'd0, vecs[i].all});
      check($sformatf("vec_any_%0d", i), {31'd0, y_any}, {31'd0, vecs[i].any});
    end

    // Reset held for two edges, inputs go high during the second
    @(negedge clk);
    rst_n = 1'b0; a = 4'h0; b = 4'h0;
    tick();
    check("rst1_yq", {28'd0, y_q}, 0);
    check_cnt("rst1", 0, 0);
    a = 4'hF; b = 4'hF;
    tick();
    check("rst2_yq", {28'd0, y_q}, 0);
    check_cnt("rst2", 0, 0);
    rst_n = 1'b1;
    tick();
    check("rel_yq", {28'd0, y_q}, 32'hF);
    check_cnt("rel", 1, 1);

    // y_any pattern 1,1,0,1 after a fresh reset
    rst_n = 1'b0; a = 4'h0; b = 4'h0;
    tick();
    rst_n = 1'b1; a = 4'hF;
    b = 4'h1; tick();
    b = 4'h2; tick();
    check_cnt("pat2", 2, 1);
    b = 4'h0; tick();
    check("pat_yq0", {28'd0, y_q}, 0);
    b = 4'h1; tick();
    check_cnt("pat4", 3, 2);
    check("pat_yq", {28'd0, y_q}, 32'h1);

    // Saturation at CNT_W=3
    rst_n = 1'b0; a = 4'h0; b = 4'h0;
    tick();
    rst_n = 1'b1; a = 4'hF; b = 4'hF;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check_cnt("sat7", 7, 1);
    end
    check_cnt("sat10", 7, 1);

    // clr zeroes counters while y_q still loads
    clr = 1'b1; a = 4'h3; b = 4'h3;
    tick();
    check_cnt("clr", 0, 0);
    check("clr_yq", {28'd0, y_q}, 32'h3);
    clr = 1'b0;
    tick();
    check_cnt("post_clr", 1, 0);

    // Reset wins over clr
    rst_n = 1'b0; clr = 1'b1;
    tick();
    check("rstclr_yq", {28'd0, y_q}, 0);
    check_cnt("rstclr", 0, 0);
    rst_n = 1'b1; clr = 1'b0;
    tick();
    check_cnt("rerise", 1, 1);
    check("rerise_yq", {28'd0, y_q}, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
